// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard scoreboard: shadows the E/M/W destination fields to produce registered
// ALU-operand forwarding selects, a combinational branch-operand select and a load-use stall.
module fwd_hazard_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_rw,
    input  logic                      id_mtr,
    input  logic                      id_is_in,
    input  logic [ADDR_W-1:0]         id_dst_addr,
    input  logic [ADDR_W-1:0]         br_src_addr,
    input  logic                      br_check,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
    output logic [1:0]                br_fwd_sel
);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : g_bad_load_lat
            $error("fwd_hazard_scoreboard: LOAD_LAT must be in 1..3, got %0d", LOAD_LAT);
        end
    endgenerate

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

    logic              r_e_v, r_e_rw, r_e_mtr, r_e_is_in;
    logic [ADDR_W-1:0] r_e_dst;
    logic              r_m_v, r_m_rw, r_m_mtr, r_m_is_in;
    logic [ADDR_W-1:0] r_m_dst;
    logic              r_w_v, r_w_rw;
    logic [ADDR_W-1:0] r_w_dst;
    logic [1:0]        r_cnt;
    logic [NUM_SRC*2-1:0] r_ex_fwd_sel;

    logic                 w_e_late, w_m_late;
    logic                 w_e_wr, w_m_wr, w_w_wr;
    logic [NUM_SRC-1:0]   w_src_hz;
    logic                 w_br_hz, w_hazard;
    logic [NUM_SRC*2-1:0] w_sel_next;

    assign w_e_late = r_e_mtr | r_e_is_in;
    assign w_m_late = r_m_mtr | r_m_is_in;
    assign w_e_wr   = r_e_v & r_e_rw;
    assign w_m_wr   = r_m_v & r_m_rw;
    assign w_w_wr   = r_w_v & r_w_rw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [ADDR_W-1:0] w_src;
            logic              w_e_hit, w_m_hit;
            assign w_src    = id_src_addr[gi*ADDR_W +: ADDR_W];
            assign w_e_hit  = w_e_wr & (r_e_dst == w_src);
            assign w_m_hit  = w_m_wr & (r_m_dst == w_src);
            assign w_src_hz[gi] = id_src_used[gi] & id_valid & w_e_hit & w_e_late;
            // Younger E result wins over M when both target the same register.
            assign w_sel_next[gi*2 +: 2] = !id_src_used[gi]       ? 2'd0 :
                                           (w_e_hit & !w_e_late) ? 2'd2 :
                                           w_m_hit               ? 2'd1 : 2'd0;
        end
    endgenerate

    assign w_br_hz  = br_check & w_e_wr & w_e_late & (r_e_dst == br_src_addr);
    assign w_hazard = (|w_src_hz) | w_br_hz;

    assign stall      = !rst & ((w_hazard & !flush) | (r_cnt != 2'd0));
    assign ex_fwd_sel = r_ex_fwd_sel;

    always_comb begin
        br_fwd_sel = 2'd0;
        if (!rst && br_check) begin
            if (w_e_wr && !w_e_late && r_e_dst == br_src_addr)
                br_fwd_sel = 2'd1;
            else if (w_m_wr && !w_m_late && r_m_dst == br_src_addr)
                br_fwd_sel = 2'd2;
            else if (w_w_wr && r_w_dst == br_src_addr)
                br_fwd_sel = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_v <= 1'b0; r_e_rw <= 1'b0; r_e_mtr <= 1'b0; r_e_is_in <= 1'b0; r_e_dst <= '0;
            r_m_v <= 1'b0; r_m_rw <= 1'b0; r_m_mtr <= 1'b0; r_m_is_in <= 1'b0; r_m_dst <= '0;
            r_w_v <= 1'b0; r_w_rw <= 1'b0; r_w_dst <= '0;
            r_cnt        <= 2'd0;
            r_ex_fwd_sel <= '0;
        end else begin
            r_w_v     <= r_m_v;
            r_w_rw    <= r_m_rw;
            r_w_dst   <= r_m_dst;
            r_m_v     <= r_e_v & !flush;
            r_m_rw    <= r_e_rw;
            r_m_mtr   <= r_e_mtr;
            r_m_is_in <= r_e_is_in;
            r_m_dst   <= r_e_dst;
            if (stall) begin
                r_e_v <= 1'b0; r_e_rw <= 1'b0; r_e_mtr <= 1'b0; r_e_is_in <= 1'b0; r_e_dst <= '0;
            end else begin
                r_e_v     <= id_valid & !flush;
                r_e_rw    <= id_rw;
                r_e_mtr   <= id_mtr;
                r_e_is_in <= id_is_in;
                r_e_dst   <= id_dst_addr;
            end
            if (flush)
                r_cnt <= 2'd0;
            else if (w_hazard && r_cnt == 2'd0)
                r_cnt <= CNT_LOAD;
            else if (r_cnt != 2'd0)
                r_cnt <= r_cnt - 2'd1;
            r_ex_fwd_sel <= (flush || stall) ? '0 : w_sel_next;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Randomized scoreboard bench: two scoreboards (LOAD_LAT 1 and 3) share the stimulus and are
// checked against a queue-of-instructions reference model.
module tb_fwd_hazard_scoreboard;
    localparam int AW = 3;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_rw, id_mtr, id_is_in, br_check, flush;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0] id_src_used;
    logic [AW-1:0] id_dst_addr, br_src_addr;
    logic          stall_a, stall_b;
    logic [NS*2-1:0] ex_a, ex_b;
    logic [1:0]    br_a, br_b;

    fwd_hazard_scoreboard #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rw(id_rw), .id_mtr(id_mtr), .id_is_in(id_is_in),
        .id_dst_addr(id_dst_addr), .br_src_addr(br_src_addr), .br_check(br_check),
        .flush(flush), .stall(stall_a), .ex_fwd_sel(ex_a), .br_fwd_sel(br_a));

    fwd_hazard_scoreboard #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rw(id_rw), .id_mtr(id_mtr), .id_is_in(id_is_in),
        .id_dst_addr(id_dst_addr), .br_src_addr(br_src_addr), .br_check(br_check),
        .flush(flush), .stall(stall_b), .ex_fwd_sel(ex_b), .br_fwd_sel(br_b));

    // In-flight instruction as the model sees it: age 1 = EX, age 2 = MEM, age 3 = WB.
    typedef struct packed { logic v; logic rw; logic late; logic [AW-1:0] dst; } ins_t;
    typedef struct packed { logic [1:0] st; logic [3:0] br; logic [7:0] ex; } exp_t;

    ins_t       pipe [2][3];
    int         stall_left [2];
    logic [3:0] ex_reg [2];
    logic       last_stall [2];
    exp_t       exp_q [$];
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;

    task automatic model_step();
        exp_t e;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            ins_t pe, pm, pw, n;
            logic hz, st;
            logic [1:0] b;
            logic [3:0] nx;
            logic [AW-1:0] s;
            if (rst) begin
                for (int a = 0; a < 3; a++) pipe[d][a] = '0;
                stall_left[d] = 0;
                ex_reg[d]     = 4'd0;
                last_stall[d] = 1'b0;
            end else begin
                pe = pipe[d][0]; pm = pipe[d][1]; pw = pipe[d][2];
                hz = 1'b0;
                nx = 4'd0;
                for (int k = 0; k < NS; k++) begin
                    s = id_src_addr[k*AW +: AW];
                    if (id_src_used[k] && id_valid && pe.v && pe.rw && pe.late && pe.dst == s) hz = 1'b1;
                    if (id_src_used[k]) begin
                        if (pe.v && pe.rw && !pe.late && pe.dst == s) nx[k*2 +: 2] = 2'd2;
                        else if (pm.v && pm.rw && pm.dst == s)         nx[k*2 +: 2] = 2'd1;
                    end
                end
                if (br_check && pe.v && pe.rw && pe.late && pe.dst == br_src_addr) hz = 1'b1;
                st = (hz && !flush) || (stall_left[d] > 0);
                b = 2'd0;
                if (br_check) begin
                    if (pe.v && pe.rw && !pe.late && pe.dst == br_src_addr)      b = 2'd1;
                    else if (pm.v && pm.rw && !pm.late && pm.dst == br_src_addr) b = 2'd2;
                    else if (pw.v && pw.rw && pw.dst == br_src_addr)            b = 2'd3;
                end
                e.st[d]        = st;
                e.br[d*2 +: 2] = b;
                e.ex[d*4 +: 4] = ex_reg[d];
                // advance the in-flight list by one clock
                pipe[d][2] = pm;
                pipe[d][1] = pe;
                pipe[d][1].v = pe.v && !flush;
                n.v = id_valid; n.rw = id_rw; n.late = id_mtr | id_is_in; n.dst = id_dst_addr;
                pipe[d][0] = (st || flush) ? ins_t'('0) : n;
                if (flush)                             stall_left[d] = 0;
                else if (hz && stall_left[d] == 0)    stall_left[d] = (d == 0 ? 1 : 3) - 1;
                else if (stall_left[d] > 0)           stall_left[d] = stall_left[d] - 1;
                ex_reg[d]     = (flush || st) ? 4'd0 : nx;
                last_stall[d] = st;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, v, input logic [AW-1:0] s0, s1, input logic [1:0] used,
                         input logic rw, mtr, isin, input logic [AW-1:0] dst, br,
                         input logic brc, fl);
        @(negedge clk);
        rst = r; id_valid = v; id_src_addr = {s1, s0}; id_src_used = used;
        id_rw = rw; id_mtr = mtr; id_is_in = isin; id_dst_addr = dst;
        br_src_addr = br; br_check = brc; flush = fl;
        #1;
        model_step();
    endtask

    // Decode holds the instruction while either scoreboard stalls.
    task automatic issue(input logic v, input logic [AW-1:0] s0, s1, input logic [1:0] used,
                         input logic rw, mtr, isin, input logic [AW-1:0] dst, br,
                         input logic brc, fl);
        drive(1'b0, v, s0, s1, used, rw, mtr, isin, dst, br, brc, fl);
        for (int n = 0; n < 6 && (last_stall[0] || last_stall[1]); n++)
            drive(1'b0, v, s0, s1, used, rw, mtr, isin, dst, br, brc, 1'b0);
    endtask

    task automatic nop(input int cnt);
        for (int i = 0; i < cnt; i++)
            issue(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus
    initial begin
        logic v, rw, mtr, isin, brc, fl;
        logic [AW-1:0] s0, s1, dst, br;
        logic [1:0] used;
        rst = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0; id_rw = 1'b0;
        id_mtr = 1'b0; id_is_in = 1'b0; id_dst_addr = '0; br_src_addr = '0;
        br_check = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        nop(1);
        // ADD R1 ; SUB R2,R1,R3
        issue(1'b1, 3'd2, 3'd3, 2'b11, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
        issue(1'b1, 3'd1, 3'd3, 2'b11, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
        nop(3);
        // ADD R1 ; NOP ; AND R4,R1,R1
        issue(1'b1, 3'd2, 3'd3, 2'b11, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
        nop(1);
        issue(1'b1, 3'd1, 3'd1, 2'b11, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
        nop(3);
        // LDD R5 ; ADD R6,R5,R0
        issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
        issue(1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0);
        nop(4);
        // load-use with flush in the second stall cycle
        drive(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b1);
        nop(4);
        // ADD R2 ; JZ R2
        issue(1'b1, 3'd1, 3'd3, 2'b11, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
        issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        nop(3);
        // IN R2 ; JZ R2
        issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        nop(3);
        // reset asserted between edges while stalled
        drive(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd5, 3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        nop(2);
        // random traffic over a small register window to provoke frequent matches
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                drive(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
            end else begin
                v    = ($urandom_range(0, 9) != 0);
                s0   = 3'($urandom_range(0, 3));
                s1   = 3'($urandom_range(0, 3));
                used = 2'($urandom_range(0, 3));
                rw   = ($urandom_range(0, 3) != 0);
                mtr  = ($urandom_range(0, 3) == 0);
                isin = ($urandom_range(0, 7) == 0);
                dst  = 3'($urandom_range(0, 3));
                br   = 3'($urandom_range(0, 3));
                brc  = ($urandom_range(0, 2) == 0);
                fl   = ($urandom_range(0, 12) == 0);
                issue(v, s0, s1, used, rw, mtr, isin, dst, br, brc, fl);
            end
        end
        nop(4);
        done = 1'b1;
    end

    // Monitor: one expected entry per clock, compared before the next rising edge
    initial begin
        exp_t e;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            #3;
            if (done && exp_q.size() == 0) break;
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("stall_lat1",  {7'd0, stall_a}, {7'd0, e.st[0]});
            chk("br_sel_lat1", {6'd0, br_a},    {6'd0, e.br[1:0]});
            chk("ex_sel_lat1", {4'd0, ex_a},    {4'd0, e.ex[3:0]});
            chk("stall_lat3",  {7'd0, stall_b}, {7'd0, e.st[1]});
            chk("br_sel_lat3", {6'd0, br_b},    {6'd0, e.br[3:2]});
            chk("ex_sel_lat3", {4'd0, ex_b},    {4'd0, e.ex[7:4]});
        end
        if (!done || exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_timeout: done=%0d pending=%0d expected done=1 pending=0",
                     done, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
